// File: rtl/decode_stage.sv
// Decode stage: captures one instruction, sequences Rn/Rm/Rd reads through the
// single register-file port, then holds the decoded bundle on a valid/ready output.
module decode_stage #(
  parameter int         DATA_W   = 16,
  parameter logic [2:0] LINK_REG = 3'd7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        rf_readnum,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        opcode,
  output logic [1:0]        op,
  output logic [2:0]        cond,
  output logic [1:0]        shift,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output logic [2:0]        writenum,
  output logic              wr_en,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  output logic [DATA_W-1:0] val_c
);

  generate
    if (DATA_W < 8) begin : g_width_check
      $error("decode_stage: DATA_W must be >= 8");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, RD_N, RD_M, RD_D, DONE} state_t;

  state_t      state_reg, state_next;
  logic [15:0] instr_reg;
  logic        need_m_reg, need_d_reg;
  logic        accept;
  logic        dec_need_n, dec_need_m, dec_need_d;
  logic [2:0]  dec_writenum;
  logic        dec_wr_en;

  assign in_ready  = !reset && !flush &&
                     ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);

  // Operand needs and destination of the incoming word, latched on accept
  always_comb begin
    dec_need_n   = 1'b0;
    dec_need_m   = 1'b0;
    dec_need_d   = 1'b0;
    dec_writenum = 3'd0;
    dec_wr_en    = 1'b0;
    case (instr[15:13])
      3'b110: begin
        dec_need_m = (instr[12:11] == 2'b00);
        if (instr[12:11] == 2'b10) begin
          dec_writenum = instr[10:8];
          dec_wr_en    = 1'b1;
        end else if (instr[12:11] == 2'b00) begin
          dec_writenum = instr[7:5];
          dec_wr_en    = 1'b1;
        end
      end
      3'b101: begin
        dec_need_n   = (instr[12:11] != 2'b11);
        dec_need_m   = 1'b1;
        dec_writenum = instr[7:5];
        dec_wr_en    = (instr[12:11] != 2'b01);
      end
      3'b011: begin
        dec_need_n   = 1'b1;
        dec_writenum = instr[7:5];
        dec_wr_en    = 1'b1;
      end
      3'b100: begin
        dec_need_n = 1'b1;
        dec_need_d = 1'b1;
      end
      3'b010: begin
        dec_need_d = !instr[11];
        if (instr[12]) begin
          dec_writenum = LINK_REG;
          dec_wr_en    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RD_N:    state_next = need_m_reg ? RD_M : (need_d_reg ? RD_D : DONE);
      RD_M:    state_next = need_d_reg ? RD_D : DONE;
      RD_D:    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_next = dec_need_n ? RD_N : (dec_need_m ? RD_M : (dec_need_d ? RD_D : DONE));
    end
    if (flush) state_next = IDLE;
  end

  always_comb begin
    rf_readnum = 3'd0;
    case (state_reg)
      RD_N:    rf_readnum = instr_reg[10:8];
      RD_M:    rf_readnum = instr_reg[2:0];
      RD_D:    rf_readnum = instr_reg[7:5];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      instr_reg  <= '0;
      need_m_reg <= 1'b0;
      need_d_reg <= 1'b0;
      writenum   <= 3'd0;
      wr_en      <= 1'b0;
      val_a      <= '0;
      val_b      <= '0;
      val_c      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        instr_reg  <= instr;
        need_m_reg <= dec_need_m;
        need_d_reg <= dec_need_d;
        writenum   <= dec_writenum;
        wr_en      <= dec_wr_en;
        val_a      <= '0;
        val_b      <= '0;
        val_c      <= '0;
      end else if (!flush) begin
        case (state_reg)
          RD_N:    val_a <= rf_rdata;
          RD_M:    val_b <= rf_rdata;
          RD_D:    val_c <= rf_rdata;
          default: ;
        endcase
      end
    end
  end

  // Field outputs are wiring off the captured instruction register
  assign opcode = instr_reg[15:13];
  assign op     = instr_reg[12:11];
  assign cond   = instr_reg[10:8];
  assign shift  = instr_reg[4:3];
  assign alu_op = instr_reg[12:11];
  assign sximm5 = {{(DATA_W-5){instr_reg[4]}}, instr_reg[4:0]};
  assign sximm8 = {{(DATA_W-8){instr_reg[7]}}, instr_reg[7:0]};

endmodule
